// File: rtl/vision_pkg.sv
// rtl/vision_pkg.sv - shared constants and helpers for the vision pipeline
//
// Purpose : common pixel/sideband widths and a constant-foldable clog2
//           used to size tap-select and counter ports.
// Ports   : none (package).
package vision_pkg;

  localparam int PIX_WIDTH  = 8;
  localparam int SB_SYNC_W  = 2;   // hsync, vsync
  localparam int SB_VALID_W = 1;
  localparam int SB_COORD_W = 12;  // per axis, x and y
  localparam int SB_WIDTH   = SB_SYNC_W + SB_VALID_W + 2 * SB_COORD_W;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one enabled register stage with async reset and sync clear
//
// Purpose : single storage element of the delay line.
// Ports   : clk, rst_n (async, active-low), ce (advance), clr (sync clear,
//           wins over ce), d (sample in), q (registered sample out).
module delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (ce) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/delay_line.sv
// rtl/delay_line.sv - clock-enabled multi-stage delay line with run-time tap select
//
// Purpose : aligns samples across paths of unequal latency; delay counted in
//           ce strobes, selectable per cycle, with a primed flag for the tap.
// Ports   : clk, rst_n (async, active-low), ce (advance), flush (sync clear),
//           delay_sel (delay minus one), d (sample in), q (selected tap),
//           primed (tap holds a real sample), fill (valid stages, saturating).
module delay_line
  import vision_pkg::*;
#(
  parameter  int WIDTH = PIX_WIDTH,
  parameter  int DEPTH = 4,
  localparam int SELW  = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [SELW-1:0]  delay_sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             primed,
  output logic [SELW:0]    fill
);

  localparam logic [SELW:0]   FILL_MAX = (SELW + 1)'(DEPTH);
  localparam logic [SELW-1:0] MAX_TAP  = SELW'(DEPTH - 1);

  logic [WIDTH-1:0] w_stage [DEPTH];
  logic [SELW-1:0]  w_eff;
  logic [WIDTH-1:0] w_q;
  logic [SELW:0]    r_fill;

  // Stage 0 takes the input, every later stage takes its predecessor.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .clr   (flush),
        .d     (d),
        .q     (w_stage[0])
      );
    end else begin : g_next
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .clr   (flush),
        .d     (w_stage[g-1]),
        .q     (w_stage[g])
      );
    end
  end

  // Counts written stages; stops at DEPTH so primed never drops under steady ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (flush) begin
      r_fill <= '0;
    end else if (ce && (r_fill != FILL_MAX)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  // Out-of-range selects (non power-of-two DEPTH) clamp to the deepest tap.
  assign w_eff = (delay_sel > MAX_TAP) ? MAX_TAP : delay_sel;

  always_comb begin
    w_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_eff == SELW'(i)) begin
        w_q = w_stage[i];
      end
    end
  end

  assign q      = w_q;
  assign primed = (r_fill > {1'b0, w_eff});
  assign fill   = r_fill;

endmodule

// File: tb/tb_delay_line.sv
// tb/tb_delay_line.sv - self-checking bench for delay_line
module tb_delay_line;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       flush;
  logic [2:0] sel;
  logic [7:0] d;

  logic [7:0] q4, q5, q1;
  logic       p4, p5, p1;
  logic [2:0] f4;
  logic [3:0] f5;
  logic [1:0] f1;

  int n_tests = 0;
  int n_fail  = 0;

  delay_line #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .delay_sel(sel[1:0]),
    .d(d), .q(q4), .primed(p4), .fill(f4)
  );

  delay_line #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .delay_sel(sel),
    .d(d), .q(q5), .primed(p5), .fill(f5)
  );

  delay_line #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .delay_sel(sel[0:0]),
    .d(d), .q(q1), .primed(p1), .fill(f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ce;
    logic       flush;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] q;
    logic       primed;
    logic [2:0] fill;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       primed;
    logic [2:0] fill;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, queue the expectation, compare after the edge.
  task automatic step(input logic c, input logic f, input logic [2:0] s, input logic [7:0] dv,
                      input logic [7:0] eq, input logic ep, input logic [2:0] ef,
                      input string tag);
    exp_t e;
    @(negedge clk);
    ce = c; flush = f; sel = s; d = dv;
    sb.push_back('{eq, ep, ef, tag});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, " q"},      q4, e.q);
      check({e.tag, " primed"}, p4, e.primed);
      check({e.tag, " fill"},   f4, e.fill);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b1; flush = 1'b0; sel = 3'd2; d = 8'hAA;

    // Reset held with ce active: nothing is captured.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst q",      q4, 0);
      check("rst primed", p4, 0);
      check("rst fill",   f4, 0);
    end
    check("rst d1 fill", f1, 0);
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b0;

    // ce, flush, sel, d, q, primed, fill
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd1,  8'd0,  1'b0, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd2,  8'd0,  1'b0, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd3,  8'd1,  1'b1, 3'd3});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd4,  8'd2,  1'b1, 3'd4});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd5,  8'd3,  1'b1, 3'd4});
    vecs.push_back('{1'b1, 1'b1, 3'd2, 8'd55, 8'd0,  1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 8'd66, 8'd66, 1'b1, 3'd1});
    vecs.push_back('{1'b0, 1'b1, 3'd2, 8'd0,  8'd0,  1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd10, 8'd0,  1'b0, 3'd1});
    vecs.push_back('{1'b0, 1'b0, 3'd2, 8'd99, 8'd0,  1'b0, 3'd1});
    vecs.push_back('{1'b0, 1'b0, 3'd2, 8'd99, 8'd0,  1'b0, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd11, 8'd0,  1'b0, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 8'd12, 8'd10, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 8'd13, 8'd10, 1'b1, 3'd4});

    foreach (vecs[i]) begin
      step(vecs[i].ce, vecs[i].flush, vecs[i].sel, vecs[i].d,
           vecs[i].q, vecs[i].primed, vecs[i].fill, $sformatf("vec%0d", i));
    end

    // Secondary depths after the stream 10,11,12,13 since the last flush.
    check("d1 q",      q1, 13);
    check("d1 primed", p1, 1);
    check("d1 fill",   f1, 1);
    check("d5 q",      q5, 10);
    check("d5 primed", p5, 1);
    check("d5 fill",   f5, 4);

    // Run-time tap change on a full line with history 1..4.
    step(1'b0, 1'b1, 3'd3, 8'd0, 8'd0, 1'b0, 3'd0, "tap flush");
    step(1'b1, 1'b0, 3'd3, 8'd1, 8'd0, 1'b0, 3'd1, "tap fill1");
    step(1'b1, 1'b0, 3'd3, 8'd2, 8'd0, 1'b0, 3'd2, "tap fill2");
    step(1'b1, 1'b0, 3'd3, 8'd3, 8'd0, 1'b0, 3'd3, "tap fill3");
    step(1'b1, 1'b0, 3'd3, 8'd4, 8'd1, 1'b1, 3'd4, "tap fill4");
    @(negedge clk);
    ce = 1'b0;
    sel = 3'd0; #1;
    check("tap sel0 q", q4, 4);
    check("tap sel0 primed", p4, 1);
    sel = 3'd3; #1;
    check("tap sel3 q", q4, 1);
    sel = 3'd7; #1;
    check("tap sel7 q", q4, 1);
    check("tap sel7 fill", f4, 4);
    check("d5 clamp q", q5, 0);
    check("d5 clamp primed", p5, 0);
    step(1'b1, 1'b0, 3'd7, 8'd5, 8'd2, 1'b1, 3'd4, "tap adv");
    check("d5 adv q",    q5, 1);
    check("d5 adv primed", p5, 1);
    check("d5 adv fill", f5, 5);

    // Asynchronous reset between edges.
    step(1'b0, 1'b1, 3'd2, 8'd0,  8'd0,  1'b0, 3'd0, "ar flush");
    step(1'b1, 1'b0, 3'd2, 8'd21, 8'd0,  1'b0, 3'd1, "ar fill1");
    step(1'b1, 1'b0, 3'd2, 8'd22, 8'd0,  1'b0, 3'd2, "ar fill2");
    step(1'b1, 1'b0, 3'd2, 8'd23, 8'd21, 1'b1, 3'd3, "ar fill3");
    @(negedge clk);
    ce = 1'b1; d = 8'd77;
    #2 rst_n = 1'b0;
    #1;
    check("ar q",      q4, 0);
    check("ar primed", p4, 0);
    check("ar fill",   f4, 0);
    check("ar d1 q",   q1, 0);
    @(posedge clk);
    #1;
    check("ar held fill", f4, 0);
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b0;

    // Saturation: fill stops at DEPTH, q lags by eff+1 strobes.
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 3'd2, 8'(k),
           (k >= 3) ? 8'(k - 2) : 8'd0,
           (k >= 3) ? 1'b1 : 1'b0,
           (k >= 4) ? 3'd4 : 3'(k),
           $sformatf("sat%0d", k));
    end
    check("sat d1 fill", f1, 1);
    check("sat d5 fill", f5, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
